// File: rtl/mctrl_pkg.sv
// Shared opcodes, FSM state type and ALU function encodings for the multicycle controller.
package mctrl_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_ADC  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_SBC  = 5'b00011;
   localparam logic [4:0] OP_CMP  = 5'b00100;
   localparam logic [4:0] OP_LHI  = 5'b00101;
   localparam logic [4:0] OP_LLI  = 5'b00110;
   localparam logic [4:0] OP_LDR  = 5'b00111;
   localparam logic [4:0] OP_STR  = 5'b01000;
   localparam logic [4:0] OP_B    = 5'b01001;
   localparam logic [4:0] OP_BEQ  = 5'b01010;
   localparam logic [4:0] OP_HALT = 5'b11111;

   // {ALUop,Flag}
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_ADC = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;
   localparam logic [1:0] ALU_SBC = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXE,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   // CMP is a SUB whose result is discarded
   function automatic logic [1:0] alu_fn(input logic [4:0] op);
      case (op)
         OP_ADC:         return ALU_ADC;
         OP_SUB, OP_CMP: return ALU_SUB;
         OP_SBC:         return ALU_SBC;
         default:        return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode classifier for the multicycle controller.
module mctrl_decode
   import mctrl_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       is_alu,
   output logic       writes_psw,
   output logic       is_mem,
   output logic       is_load,
   output logic       is_branch,
   output logic       is_cond_br,
   output logic       is_imm,
   output logic       ends_exe,
   output logic       is_halt,
   output logic       illegal
);

   always_comb begin
      is_alu     = 1'b0;
      writes_psw = 1'b0;
      is_mem     = 1'b0;
      is_load    = 1'b0;
      is_branch  = 1'b0;
      is_cond_br = 1'b0;
      is_imm     = 1'b0;
      ends_exe   = 1'b0;
      is_halt    = 1'b0;
      illegal    = 1'b0;
      case (opcode)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            is_alu     = 1'b1;
            writes_psw = 1'b1;
         end
         OP_CMP: begin
            is_alu     = 1'b1;
            writes_psw = 1'b1;
            ends_exe   = 1'b1;
         end
         OP_LHI, OP_LLI: is_imm = 1'b1;
         OP_LDR: begin
            is_mem  = 1'b1;
            is_load = 1'b1;
         end
         OP_STR:  is_mem = 1'b1;
         OP_B:    is_branch = 1'b1;
         OP_BEQ: begin
            is_cond_br = 1'b1;
            ends_exe   = 1'b1;
         end
         OP_HALT: is_halt = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXE/MEM/WB controller owning PC, IR and PSW.
// Define MCTRL_ILLEGAL_TRAP_EN to halt with a sticky Illegal flag on undefined opcodes.
module multicycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              Reset,
   output logic              MemReq,
   output logic              MemWE,
   output logic [DATA_W-1:0] MemAddr,
   input  logic [DATA_W-1:0] MemRData,
   input  logic              MemReady,
   input  logic [DATA_W-1:0] DataAddr,
   input  logic              N,
   input  logic              Z,
   input  logic              C,
   output logic [10:0]       Ins,
   output logic              WBRF,
   output logic              WBresource,
   output logic              RBresource,
   output logic              OprandB,
   output logic              LI,
   output logic              Buff_OutR,
   output logic              ALUop,
   output logic              Flag,
   output logic              PSW_C,
   output logic [2:0]        PSW,
   output logic              Halted,
   output logic              Illegal
);

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   pc, pc_nxt;
   logic [DATA_W-1:0]   ir, ir_nxt;
   logic [2:0]          psw, psw_nxt;
   logic [4:0]          opcode;
   logic                is_alu, writes_psw, is_mem, is_load, is_branch;
   logic                is_cond_br, is_imm, ends_exe, is_halt, illegal;
`ifdef MCTRL_ILLEGAL_TRAP_EN
   logic                illegal_set;
   logic                illegal_q;
`endif

   function automatic logic signed [DATA_W-1:0] sext11(input logic [10:0] v);
      return {{(DATA_W-11){v[10]}}, v};
   endfunction

   function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] v);
      return {{(DATA_W-8){v[7]}}, v};
   endfunction

   assign opcode = ir[DATA_W-1:DATA_W-5];
   assign Ins    = ir[10:0];
   assign PSW    = psw;
   assign PSW_C  = psw[0];

   mctrl_decode u_decode (
      .opcode     (opcode),
      .is_alu     (is_alu),
      .writes_psw (writes_psw),
      .is_mem     (is_mem),
      .is_load    (is_load),
      .is_branch  (is_branch),
      .is_cond_br (is_cond_br),
      .is_imm     (is_imm),
      .ends_exe   (ends_exe),
      .is_halt    (is_halt),
      .illegal    (illegal)
   );

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         ir    <= '0;
         psw   <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
         psw   <= psw_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      ir_nxt     = ir;
      psw_nxt    = psw;
      MemReq     = 1'b0;
      MemWE      = 1'b0;
      MemAddr    = '0;
      WBRF       = 1'b0;
      WBresource = 1'b0;
      RBresource = 1'b0;
      OprandB    = 1'b0;
      LI         = 1'b0;
      Buff_OutR  = 1'b0;
      ALUop      = 1'b0;
      Flag       = 1'b0;
      Halted     = 1'b0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      illegal_set = 1'b0;
`endif
      unique case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            MemReq  = 1'b1;
            MemAddr = pc;
            if (MemReady) begin
               ir_nxt    = MemRData;
               pc_nxt    = pc + DATA_W'(1);
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            RBresource = (opcode == OP_STR) || (opcode == OP_LHI);
            if (is_branch) begin
               pc_nxt    = pc + sext11(ir[10:0]);
               state_nxt = S_FETCH;
            end else if (is_halt) begin
               state_nxt = S_HALT;
            end else if (illegal) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
               illegal_set = 1'b1;
               state_nxt   = S_HALT;
`else
               state_nxt   = S_FETCH;
`endif
            end else begin
               state_nxt = S_EXE;
            end
         end
         S_EXE: begin
            if (is_alu) begin
               {ALUop, Flag} = alu_fn(opcode);
               Buff_OutR     = 1'b1;
            end
            if (writes_psw) psw_nxt = {N, Z, C};
            if (is_imm) begin
               OprandB = 1'b1;
               LI      = (opcode == OP_LHI);
            end
            // BEQ tests the PSW left by an earlier instruction
            if (is_cond_br && psw[1]) pc_nxt = pc + sext8(ir[7:0]);
            if (is_mem)        state_nxt = S_MEM;
            else if (ends_exe) state_nxt = S_FETCH;
            else               state_nxt = S_WB;
         end
         S_MEM: begin
            MemReq  = 1'b1;
            MemAddr = DataAddr;
            MemWE   = !is_load;
            if (MemReady) state_nxt = is_load ? S_WB : S_FETCH;
         end
         S_WB: begin
            WBRF       = 1'b1;
            WBresource = is_load;
            state_nxt  = S_FETCH;
         end
         S_HALT:  Halted = 1'b1;
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef MCTRL_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset)           illegal_q <= 1'b0;
      else if (illegal_set) illegal_q <= 1'b1;
   end
   assign Illegal = illegal_q;
`else
   assign Illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that sits directly upstream of the register-file/ALU datapath (RFplusALU). It owns PC, IR and the PSW flag register. It fetches 16-bit instructions over a unified memory handshake and sequences FETCH/DECODE/EXE/MEM/WB. It drives the datapath's instruction field and every per-cycle control strobe the datapath consumes.

## Interface
- DATA_W, 16, data, address and instruction width
- RESET_PC, 16'h0000, PC value loaded at reset
- clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- MemReq  out  1  memory access request; held until MemReady
- MemWE  out  1  write strobe; valid only with MemReq
- MemAddr  out  16  PC in FETCH; DataAddr in MEM
- MemRData  in  16  read data; captured into IR in FETCH
- MemReady  in  1  access complete this cycle
- DataAddr  in  16  load/store address from datapath (Rm)
- N, Z, C  in  1 each  datapath ALU flags, valid in EXE
- Ins  out  11  IR[10:0] to datapath: Rd=[10:8], Rm=[7:5], Rn=[4:2], imm8=[7:0]
- WBRF  out  1  register-file write enable
- WBresource  out  1  write-back source: 0 = WBData, 1 = MEMData
- RBresource  out  1  read port B address: 0 = Ins[4:2], 1 = Ins[10:8]
- OprandB  out  1  ALU operand B: 0 = register, 1 = immediate
- LI  out  1  immediate form: 1 = LHI, 0 = LLI
- Buff_OutR  out  1  latch ALU result into OutR
- ALUop, Flag  out  1 each  ALU function {ALUop,Flag}: 00 ADD, 01 ADC, 10 SUB, 11 SBC
- PSW_C  out  1  stored carry flag
- PSW  out  3  {N,Z,C} register
- Halted  out  1  high in HALT
- Illegal  out  1  sticky illegal-opcode indicator (only with the trap macro)

## Operation
- IR[15:11] opcode: ADD 00000, ADC 00001, SUB 00010, SBC 00011, CMP 00100, LHI 00101, LLI 00110, LDR 00111 (Rd=MEM[Rm]), STR 01000 (MEM[Rm]=Rd), B 01001, BEQ 01010, HALT 11111. All other opcodes are illegal.
- States: IDLE, FETCH, DECODE, EXE, MEM, WB, HALT. Reset enters IDLE.
- IDLE -> FETCH, unconditionally.
- FETCH: MemReq=1, MemAddr=PC. Holds until MemReady. On MemReady: IR<=MemRData, PC<=PC+1, go to DECODE.
- DECODE: RBresource=1 for STR/LHI, otherwise 0. Transitions:
  - B: PC<=PC+sext(IR[10:0]), go to FETCH.
  - HALT: go to HALT.
  - Illegal opcode: go to FETCH (NOP).
  - Everything else: go to EXE.
- EXE:
  - ALU ops drive {ALUop,Flag} and Buff_OutR=1. PSW<={N,Z,C} for ADD/ADC/SUB/SBC/CMP.
  - CMP uses SUB encoding and then goes to FETCH. Other ALU ops go to WB.
  - LHI/LLI drive LI and OprandB=1, then go to WB.
  - LDR/STR go to MEM.
  - BEQ: if PSW.Z, PC<=PC+sext(IR[7:0]). Go to FETCH.
- MEM: MemReq=1, MemAddr=DataAddr, MemWE=(STR). Holds until MemReady, then LDR goes to WB and STR goes to FETCH.
- WB: WBRF=1, WBresource=(LDR). Go to FETCH.
- HALT: terminal; only Reset exits.
- Control outputs are combinational from state+IR. Every strobe not listed for a state is 0.
- PC arithmetic is modulo 2^16. 16'hFFFF+1 wraps to 0.

## Timing
- Reset values: state IDLE, PC=RESET_PC, IR=0, PSW=0, Illegal=0, Halted=0, all outputs 0 (including MemReq).
- Reset asserted mid-access drops MemReq immediately. The in-flight access is abandoned and no PC/IR update occurs.
- Cycles with zero-wait memory: ALU op 4, CMP 3, LHI/LLI 4, LDR 5, STR 4, B 2, BEQ 3. Each MemReady stall adds one cycle.
- MemAddr/MemWE are stable for the whole MemReq interval.
- MemReady sampled outside FETCH/MEM is ignored.
- PSW updates at the EXE->next edge. BEQ reads the PSW produced by an earlier instruction.
- Ins changes only on the FETCH->DECODE edge.

## Configuration
- MCTRL_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE sets Illegal (sticky until Reset) and enters HALT; Halted=1.
- Not defined: an illegal opcode is a 2-cycle NOP; the Illegal port is tied to 0.

## Structure
- Package mctrl_pkg: opcode localparams, state enum typedef, ALU function encodings {ALUop,Flag}.
- Sub-module mctrl_decode: combinational opcode -> instruction-class flags (is_alu, writes_psw, is_mem, is_load, is_branch, illegal). The FSM, PC, IR and PSW stay in the top.

## Test plan
- Reset released, memory ready: cycle 1 IDLE, cycle 2 MemReq=1 with MemAddr=0000. Word 16'h0060 (ADD R0,R3,R0) -> PC=1, then Buff_OutR=1 with {ALUop,Flag}=00, then WBRF=1, WBresource=0; total 4 cycles after IDLE.
- SUB with datapath Z=1, C=1, followed by BEQ offset +2 at PC=5 -> PC=8 after BEQ. With Z=0 -> PC=6.
- LDR with MemReady delayed 3 cycles in MEM -> MemAddr=DataAddr held for 4 cycles, then WBRF=1, WBresource=1; PSW unchanged.
- B offset 11'h7FF from PC=0 -> PC=0000 (0+1-1). B offset -2 from PC=FFFF -> wrap-around checked.
- Opcode 10101: without macro, back to FETCH with PC+1 and no strobes. With MCTRL_ILLEGAL_TRAP_EN, Illegal=1 and Halted=1 persist until Reset.
- Reset asserted during a stalled FETCH -> MemReq=0 within the same cycle and PC=RESET_PC. After release, fetch restarts at RESET_PC.
